// File: rtl/outpkt_v1.sv
// Version-1 output packet framer: header, header checksum, zero-latency
// payload pass-through and payload checksum toward the output byte FIFO.
module outpkt_v1 #(
    parameter logic [7:0]  VERSION     = 8'd1,
    parameter int unsigned PKT_MAX_LEN = 65536
) (
    input  logic        CLK,
    input  logic        rst,
    input  logic        start_valid,
    output logic        start_ready,
    input  logic [7:0]  pkt_type,
    input  logic [15:0] pkt_id,
    input  logic [23:0] pkt_len,
    input  logic [7:0]  data_in,
    input  logic        data_empty,
    output logic        data_rd_en,
    output logic [7:0]  dout,
    output logic        dout_wr_en,
    input  logic        dout_full,
    output logic        err_pkt_type,
    output logic        err_pkt_len
);

    typedef enum logic [2:0] {IDLE, HDR, HCSUM, DATA, DCSUM} state_t;

    state_t      state, state_nxt;
    logic [3:0]  hdr_cnt;
    logic [1:0]  cs_cnt;
    logic [23:0] data_cnt;
    logic [7:0]  type_q;
    logic [15:0] id_q;
    logic [23:0] len_q;
    logic [31:0] word_q;
    logic [31:0] sum_q;

    logic        accept;
    logic        bad_type;
    logic        bad_len;
    logic [7:0]  hdr_byte;
    logic [31:0] sum_inv;
    logic [1:0]  lane;
    logic        sect_last;
    logic        word_end;
    logic [31:0] merged;

    assign accept   = start_valid & start_ready;
    assign bad_type = (pkt_type == 8'd0);
    assign bad_len  = (pkt_len == 24'd0) || (32'(pkt_len) > PKT_MAX_LEN);
    assign sum_inv  = ~sum_q;

    always_comb begin
        case (hdr_cnt)
            4'd0:    hdr_byte = VERSION;
            4'd1:    hdr_byte = type_q;
            4'd4:    hdr_byte = len_q[7:0];
            4'd5:    hdr_byte = len_q[15:8];
            4'd6:    hdr_byte = len_q[23:16];
            4'd8:    hdr_byte = id_q[7:0];
            4'd9:    hdr_byte = id_q[15:8];
            default: hdr_byte = 8'd0;
        endcase
    end

    // NOTE: every output of this block is defaulted first so no path can infer a latch.
    always_comb begin
        state_nxt   = state;
        start_ready = 1'b0;
        dout_wr_en  = 1'b0;
        data_rd_en  = 1'b0;
        dout        = 8'd0;
        lane        = 2'd0;
        sect_last   = 1'b0;
        case (state)
            IDLE: begin
                start_ready = 1'b1;
                if (accept && !bad_type && !bad_len) state_nxt = HDR;
            end
            HDR: begin
                dout_wr_en = ~dout_full;
                dout       = hdr_byte;
                lane       = hdr_cnt[1:0];
                sect_last  = (hdr_cnt == 4'd9);
                if (dout_wr_en && sect_last) state_nxt = HCSUM;
            end
            HCSUM: begin
                dout_wr_en = ~dout_full;
                dout       = sum_inv[{cs_cnt, 3'b000} +: 8];
                if (dout_wr_en && cs_cnt == 2'd3) state_nxt = DATA;
            end
            DATA: begin
                dout_wr_en = ~data_empty & ~dout_full;
                data_rd_en = ~data_empty & ~dout_full;
                dout       = data_in;
                lane       = data_cnt[1:0];
                sect_last  = (data_cnt == len_q - 24'd1);
                if (dout_wr_en && sect_last) state_nxt = DCSUM;
            end
            DCSUM: begin
                dout_wr_en = ~dout_full;
                dout       = sum_inv[{cs_cnt, 3'b000} +: 8];
                if (dout_wr_en && cs_cnt == 2'd3) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Folding the final partial word into the sum on the last byte lets the
    // checksum byte follow in the very next cycle.
    assign merged   = word_q | (32'(dout) << {lane, 3'b000});
    assign word_end = (lane == 2'd3) || sect_last;

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge CLK) begin
        if (rst) begin
            state        <= IDLE;
            hdr_cnt      <= 4'd0;
            cs_cnt       <= 2'd0;
            data_cnt     <= 24'd0;
            type_q       <= 8'd0;
            id_q         <= 16'd0;
            len_q        <= 24'd0;
            word_q       <= 32'd0;
            sum_q        <= 32'd0;
            err_pkt_type <= 1'b0;
            err_pkt_len  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                type_q       <= pkt_type;
                id_q         <= pkt_id;
                len_q        <= pkt_len;
                hdr_cnt      <= 4'd0;
                cs_cnt       <= 2'd0;
                word_q       <= 32'd0;
                sum_q        <= 32'd0;
                err_pkt_type <= err_pkt_type | bad_type;
                err_pkt_len  <= err_pkt_len | bad_len;
            end
            if (dout_wr_en) begin
                case (state)
                    HDR, DATA: begin
                        if (state == HDR) hdr_cnt  <= hdr_cnt + 4'd1;
                        else              data_cnt <= data_cnt + 24'd1;
                        if (word_end) begin
                            sum_q  <= sum_q + merged;
                            word_q <= 32'd0;
                        end else begin
                            word_q <= merged;
                        end
                    end
                    HCSUM: begin
                        cs_cnt <= cs_cnt + 2'd1;
                        if (cs_cnt == 2'd3) begin
                            sum_q    <= 32'd0;
                            word_q   <= 32'd0;
                            data_cnt <= 24'd0;
                        end
                    end
                    DCSUM:   cs_cnt <= cs_cnt + 2'd1;
                    default: ;
                endcase
            end
        end
    end

endmodule
